// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU front-end types and constants
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // Fetch-to-decode packet; also the payload type of the downstream skid buffer.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

  // Instructions are word aligned, so redirect targets drop their low bits.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - in-order circular buffer pairing fetch PCs with returned instructions
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             alloc_i,
  input  logic [XLEN-1:0]  alloc_pc_i,
  input  logic             fill_i,
  input  logic [XLEN-1:0]  fill_instr_i,
  input  logic             pop_i,
  output logic [XLEN-1:0]  head_pc_o,
  output logic [XLEN-1:0]  head_instr_o,
  output logic             head_filled_o,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] unfilled_o
);

  logic [XLEN-1:0]  pc_mem   [DEPTH];
  logic [XLEN-1:0]  instr_mem[DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PTR_W-1:0] alloc_ptr_q;
  logic [PTR_W-1:0] fill_ptr_q;
  logic [PTR_W-1:0] head_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] unfilled_q;

  // Pointer, occupancy and filled-flag bookkeeping; a flush empties everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      unfilled_q  <= '0;
    end else if (flush_i) begin
      filled_q    <= '0;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      unfilled_q  <= '0;
    end else begin
      // The alloc slot is free and the fill slot is allocated, so they never collide.
      if (alloc_i) begin
        filled_q[alloc_ptr_q] <= 1'b0;
        alloc_ptr_q           <= alloc_ptr_q + PTR_W'(1);
      end
      if (fill_i) begin
        filled_q[fill_ptr_q] <= 1'b1;
        fill_ptr_q           <= fill_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        head_ptr_q <= head_ptr_q + PTR_W'(1);
      end
      count_q    <= count_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
      unfilled_q <= unfilled_q + CNT_W'(alloc_i) - CNT_W'(fill_i);
    end
  end

  // Payload storage needs no reset: the filled flags and count gate its visibility.
  always_ff @(posedge clk) begin
    if (alloc_i) begin
      pc_mem[alloc_ptr_q] <= alloc_pc_i;
    end
    if (fill_i) begin
      instr_mem[fill_ptr_q] <= fill_instr_i;
    end
  end

  assign head_pc_o     = pc_mem[head_ptr_q];
  assign head_instr_o  = instr_mem[head_ptr_q];
  assign head_filled_o = filled_q[head_ptr_q];
  assign count_o       = count_q;
  assign unfilled_o    = unfilled_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC generation, request issue, redirect and stale-response dropping
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              MAX_INFLIGHT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output fetch_pkt_t      fetch_pkt
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [XLEN-1:0]  head_pc;
  logic [XLEN-1:0]  head_instr;
  logic             head_filled;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] unfilled;
  logic [CNT_W:0]   credits_used;

  logic req_fire;
  logic rsp_drop;
  logic rsp_fill;
  logic pop;

  // Credits come from registered counts only, so a same-cycle pop frees nothing until next cycle.
  assign credits_used   = {1'b0, count} + {1'b0, drop_q};
  assign imem_req_valid = !reset && !redirect_valid &&
                          (credits_used < (CNT_W + 1)'(MAX_INFLIGHT));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses owed to squashed requests come first and are swallowed here.
  assign rsp_drop = imem_rsp_valid && (drop_q != '0);
  assign rsp_fill = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

  assign fetch_valid = !reset && (count != '0) && head_filled && !redirect_valid;
  assign pop         = fetch_valid && fetch_ready;
  assign fetch_pkt   = reset ? '0 : fetch_pkt_t'{pc: head_pc, instr: head_instr};

  fetch_queue #(
    .DEPTH (MAX_INFLIGHT)
  ) u_queue (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (redirect_valid),
    .alloc_i       (req_fire),
    .alloc_pc_i    (pc_q),
    .fill_i        (rsp_fill),
    .fill_instr_i  (imem_rsp_data),
    .pop_i         (pop),
    .head_pc_o     (head_pc),
    .head_instr_o  (head_instr),
    .head_filled_o (head_filled),
    .count_o       (count),
    .unfilled_o    (unfilled)
  );

  // Next PC and drop count; a redirect turns every unfilled entry into a future drop.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d = align_pc(redirect_pc);
      // A coincident response consumes either an old drop or one of the unfilled entries.
      drop_d = drop_q + unfilled - CNT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d = pc_q + PC_STEP;
      end
      if (rsp_drop) begin
        drop_d = drop_q - CNT_W'(1);
      end
    end
  end

  // PC and drop-count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  a_rsp_expected : assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (({1'b0, unfilled} + {1'b0, drop_q}) != '0));

  a_occupancy : assert property (@(posedge clk) disable iff (reset)
    count <= CNT_W'(MAX_INFLIGHT));

  a_pkt_stable : assert property (@(posedge clk) disable iff (reset)
    (fetch_valid && !fetch_ready) |=> $stable(fetch_pkt));

endmodule
